// File: rtl/uart_alu_defs_pkg.sv
// Shared definitions for the UART ALU command protocol: widths, opcodes,
// request frame byte order and host FSM state encodings.
package uart_alu_defs;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_OPCODE_SZ  = 6;

  // ALU opcodes understood by the responder
  localparam logic [DEF_OPCODE_SZ-1:0] OP_ADD = 6'h20;
  localparam logic [DEF_OPCODE_SZ-1:0] OP_SUB = 6'h22;
  localparam logic [DEF_OPCODE_SZ-1:0] OP_AND = 6'h24;
  localparam logic [DEF_OPCODE_SZ-1:0] OP_OR  = 6'h25;
  localparam logic [DEF_OPCODE_SZ-1:0] OP_XOR = 6'h26;
  localparam logic [DEF_OPCODE_SZ-1:0] OP_NOR = 6'h27;
  localparam logic [DEF_OPCODE_SZ-1:0] OP_SRL = 6'h02;
  localparam logic [DEF_OPCODE_SZ-1:0] OP_SRA = 6'h03;

  // Request frame: operand A first, then operand B, then the opcode byte
  localparam int BYTE_IDX_A   = 0;
  localparam int BYTE_IDX_B   = 1;
  localparam int BYTE_IDX_OP  = 2;
  localparam int FRAME_BYTES  = 3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SEND_A   = 3'd1,
    ST_SEND_B   = 3'd2,
    ST_SEND_OP  = 3'd3,
    ST_WAIT_RES = 3'd4
  } state_t;

endpackage

// File: rtl/uart_alu_host_timeout_counter.sv
// Response timeout counter: counts enabled cycles from a synchronous clear
// and flags the terminal count TIMEOUT_CYCLES-1, where it then holds.
module timeout_counter #(
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int TO_W           = $clog2(TIMEOUT_CYCLES)
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_tc
);

  localparam logic [TO_W-1:0] TC_VAL = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] count;

  // Count up while enabled; stop at terminal count so the flag cannot wrap
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)
      count <= '0;
    else if (i_clear)
      count <= '0;
    else if (i_enable && !o_tc)
      count <= count + 1'b1;
  end

  assign o_tc = (count == TC_VAL);

endmodule

// File: rtl/uart_alu_host.sv
// Host-side initiator for the UART ALU protocol: sends A, B, opcode into the
// TX FIFO, then waits (with timeout) for one result byte from the RX FIFO.
//
// state       | meaning
// ------------+------------------------------------------------------------
// ST_IDLE     | ready for a request; drains stale RX bytes first
// ST_SEND_A   | pushing latched operand A (held while TX full)
// ST_SEND_B   | pushing latched operand B
// ST_SEND_OP  | pushing zero-extended opcode
// ST_WAIT_RES | waiting for result byte; timeout counter running
module uart_alu_host
  import uart_alu_defs::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int OPCODE_SZ      = DEF_OPCODE_SZ,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int TO_W           = $clog2(TIMEOUT_CYCLES)
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [DATA_WIDTH-1:0] i_op_a,
  input  logic [DATA_WIDTH-1:0] i_op_b,
  input  logic [OPCODE_SZ-1:0]  i_op_code,
  input  logic                  i_tx_full,
  input  logic                  i_rx_empty,
  input  logic [DATA_WIDTH-1:0] i_r_data,
  output logic [DATA_WIDTH-1:0] o_w_data,
  output logic                  o_wr_uart,
  output logic                  o_rd_uart,
  output logic                  o_ready,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_timeout,
  output logic [DATA_WIDTH-1:0] o_result
);

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] op_a_q, op_b_q;
  logic [OPCODE_SZ-1:0]  op_code_q;
  logic                  accept;
  logic                  cnt_en;
  logic                  to_tc;

  timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TO_W           (TO_W)
  ) u_timeout (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_clear  (accept),
    .i_enable (cnt_en),
    .o_tc     (to_tc)
  );

  // State register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  // Next-state logic: each send state advances only on a cycle that pushes
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (i_rx_empty && i_start) state_nxt = ST_SEND_A;
      ST_SEND_A:   if (!i_tx_full)            state_nxt = ST_SEND_B;
      ST_SEND_B:   if (!i_tx_full)            state_nxt = ST_SEND_OP;
      ST_SEND_OP:  if (!i_tx_full)            state_nxt = ST_WAIT_RES;
      ST_WAIT_RES: if (!i_rx_empty || to_tc)  state_nxt = ST_IDLE;
      default:                                state_nxt = ST_IDLE;
    endcase
  end

  // Output decode; every strobe is suppressed while reset is held
  always_comb begin
    o_w_data  = '0;
    o_wr_uart = 1'b0;
    o_rd_uart = 1'b0;
    o_ready   = 1'b0;
    o_busy    = 1'b0;
    accept    = 1'b0;
    cnt_en    = 1'b0;
    if (!i_reset) begin
      case (state)
        ST_IDLE: begin
          o_ready   = i_rx_empty;
          o_rd_uart = !i_rx_empty;
          accept    = i_rx_empty && i_start;
        end
        ST_SEND_A: begin
          o_busy    = 1'b1;
          o_wr_uart = !i_tx_full;
          o_w_data  = op_a_q;
        end
        ST_SEND_B: begin
          o_busy    = 1'b1;
          o_wr_uart = !i_tx_full;
          o_w_data  = op_b_q;
        end
        ST_SEND_OP: begin
          o_busy    = 1'b1;
          o_wr_uart = !i_tx_full;
          o_w_data  = DATA_WIDTH'(op_code_q);
        end
        ST_WAIT_RES: begin
          o_busy    = 1'b1;
          o_rd_uart = !i_rx_empty;
          cnt_en    = i_rx_empty;
        end
        default: ;
      endcase
    end
  end

  // Request latch, result capture and registered done/timeout pulse
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      op_a_q    <= '0;
      op_b_q    <= '0;
      op_code_q <= '0;
      o_result  <= '0;
      o_done    <= 1'b0;
      o_timeout <= 1'b0;
    end else begin
      o_done    <= 1'b0;
      o_timeout <= 1'b0;
      if (accept) begin
        op_a_q    <= i_op_a;
        op_b_q    <= i_op_b;
        op_code_q <= i_op_code;
      end
      if (state == ST_WAIT_RES) begin
        // A byte present on the terminal-count cycle still counts as a result
        if (!i_rx_empty) begin
          o_result <= i_r_data;
          o_done   <= 1'b1;
        end else if (to_tc) begin
          o_done    <= 1'b1;
          o_timeout <= 1'b1;
        end
      end
    end
  end

endmodule
